// File: rtl/line_clear_pkg.sv
// Shared constants for the line-clear sequencer: FSM state codes, default sizes
// and the per-lock score table used when LINE_CLEAR_SCORE_EN is defined.
package line_clear_pkg;

  localparam int ROWS_DEF    = 20;
  localparam int IDX_W_DEF   = 6;
  localparam int TOTAL_W_DEF = 16;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETTLE = 3'd1;
  localparam logic [2:0] SCAN   = 3'd2;
  localparam logic [2:0] SHIFT  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [11:0] SCORE_1 = 12'd40;
  localparam logic [11:0] SCORE_2 = 12'd100;
  localparam logic [11:0] SCORE_3 = 12'd300;
  localparam logic [11:0] SCORE_4 = 12'd1200;

  function automatic logic [11:0] score_for(input logic [2:0] n);
    case (n)
      3'd0:    return 12'd0;
      3'd1:    return SCORE_1;
      3'd2:    return SCORE_2;
      3'd3:    return SCORE_3;
      default: return SCORE_4;
    endcase
  endfunction

endpackage

// File: rtl/full_row_finder.sv
// Combinational priority encoder over the row_full flags; the highest index
// (lowest row on screen) wins. No latency, no flow control.
module full_row_finder #(
  parameter int ROWS  = 20,
  parameter int IDX_W = 6
) (
  input  logic [ROWS-1:0]  row_full,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (row_full[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: after lock_pulse, repeatedly shifts the board down over the lowest
// full row until none remain; clear_done 3+3n cycles later. Optional score: LINE_CLEAR_SCORE_EN.
module line_clear_ctrl
  import line_clear_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int TOTAL_W = TOTAL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lock_pulse,
  input  logic [ROWS-1:0]    row_full,
  output logic [ROWS-1:0]    advance_row,
  output logic               busy,
  output logic               clear_done,
  output logic [2:0]         lines_this_lock,
  output logic [TOTAL_W-1:0] lines_total
`ifdef LINE_CLEAR_SCORE_EN
  ,
  output logic [11:0]        score_delta
`endif
);

  logic [2:0]         state;
  logic [2:0]         count;
  logic               found;
  logic [IDX_W-1:0]   idx;
  logic [TOTAL_W:0]   total_sum;
  logic [TOTAL_W-1:0] total_sat;

  full_row_finder #(
    .ROWS  (ROWS),
    .IDX_W (IDX_W)
  ) u_finder (
    .row_full (row_full),
    .found    (found),
    .idx      (idx)
  );

  function automatic logic [ROWS-1:0] fill_mask(input logic [IDX_W-1:0] k);
    logic [ROWS-1:0] m;
    for (int i = 0; i < ROWS; i++) begin
      m[i] = (i <= int'(k));
    end
    return m;
  endfunction

  assign total_sum = {1'b0, lines_total} + {{(TOTAL_W - 2){1'b0}}, count};
  assign total_sat = total_sum[TOTAL_W] ? {TOTAL_W{1'b1}} : total_sum[TOTAL_W-1:0];
  assign busy      = (state != IDLE);

  // Strobes and result registers load on the SCAN exit edge so they are valid
  // exactly while the FSM sits in SHIFT or DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      count           <= 3'd0;
      advance_row     <= '0;
      clear_done      <= 1'b0;
      lines_this_lock <= 3'd0;
      lines_total     <= '0;
`ifdef LINE_CLEAR_SCORE_EN
      score_delta     <= 12'd0;
`endif
    end else begin
      advance_row <= '0;
      clear_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (lock_pulse) state <= SETTLE;
        end
        SETTLE: begin
          state <= SCAN;
        end
        SCAN: begin
          if (found) begin
            state       <= SHIFT;
            advance_row <= fill_mask(idx);
            count       <= (count == 3'd7) ? count : count + 3'd1;
          end else begin
            state           <= DONE;
            clear_done      <= 1'b1;
            lines_this_lock <= count;
            lines_total     <= total_sat;
`ifdef LINE_CLEAR_SCORE_EN
            score_delta     <= score_for(count);
`endif
            count           <= 3'd0;
          end
        end
        SHIFT: begin
          state <= SETTLE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Bench for line_clear_ctrl: a playfield model reacts to advance_row, and a board-level
// reference predicts the shift masks, counts, totals and clear_done timing for each lock.
module tb_line_clear_ctrl;

  localparam int ROWS = 20;
  localparam int TW   = 8;  // narrow total so saturation is reachable in a short run
  localparam longint TOTAL_MAX = (64'd1 << TW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            lock_pulse;
  logic [ROWS-1:0] row_full;
  logic [ROWS-1:0] advance_row;
  logic            busy;
  logic            clear_done;
  logic [2:0]      lines_this_lock;
  logic [TW-1:0]   lines_total;
`ifdef LINE_CLEAR_SCORE_EN
  logic [11:0]     score_delta;
`endif

  line_clear_ctrl #(.ROWS(ROWS), .IDX_W(6), .TOTAL_W(TW)) dut (
    .clk             (clk),
    .reset           (reset),
    .lock_pulse      (lock_pulse),
    .row_full        (row_full),
    .advance_row     (advance_row),
    .busy            (busy),
    .clear_done      (clear_done),
    .lines_this_lock (lines_this_lock),
    .lines_total     (lines_total)
`ifdef LINE_CLEAR_SCORE_EN
    ,
    .score_delta     (score_delta)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [ROWS-1:0] board;
  logic [ROWS-1:0] pend;
  longint exp_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Playfield model: a strobe seen in one cycle moves the rows at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (pend[i]) board[i] = (i == 0) ? 1'b0 : board[i-1];
    end
    row_full = board;
    pend = advance_row;
  endtask

  function automatic int top_row(input logic [ROWS-1:0] b);
    for (int i = ROWS - 1; i >= 0; i--) if (b[i]) return i;
    return -1;
  endfunction

  function automatic logic [ROWS-1:0] mask_of(input int k);
    logic [ROWS:0] t;
    t = ({{ROWS{1'b0}}, 1'b1} << (k + 1)) - 1;
    return t[ROWS-1:0];
  endfunction

  function automatic longint score_ref(input int n);
    if (n == 0) return 0;
    if (n == 1) return 40;
    if (n == 2) return 100;
    if (n == 3) return 300;
    return 1200;
  endfunction

  // exp_n_tab / exp_lines_tab < 0 means "take them from the reference".
  task automatic run_lock(input logic [ROWS-1:0] init, input bit inject,
                          input int exp_n_tab, input int exp_lines_tab);
    logic [ROWS-1:0] b, m;
    logic [ROWS-1:0] exp_masks[$];
    logic [ROWS-1:0] got[$];
    int n, lines, done_cnt, done_cyc, busy_err, limit, k;
    b = init;
    while (b != '0) begin
      k = top_row(b);
      m = mask_of(k);
      exp_masks.push_back(m);
      b = (b & ~m) | ((b << 1) & m);
    end
    n = (exp_n_tab >= 0) ? exp_n_tab : exp_masks.size();
    lines = (exp_lines_tab >= 0) ? exp_lines_tab : ((n > 7) ? 7 : n);
    exp_total = exp_total + lines;
    if (exp_total > TOTAL_MAX) exp_total = TOTAL_MAX;

    board = init;
    row_full = board;
    pend = '0;
    lock_pulse = 1'b1;
    step();
    lock_pulse = 1'b0;
    done_cnt = 0;
    done_cyc = -1;
    busy_err = 0;
    limit = 2 + 3 * n + 3;
    for (int c = 0; c <= limit; c++) begin
      if (c > 0) begin
        if (inject && c == 2) lock_pulse = 1'b1;
        step();
        lock_pulse = 1'b0;
      end
      if (advance_row != '0) got.push_back(advance_row);
      if (clear_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy !== (c <= 2 + 3 * n)) busy_err++;
    end
    // clear_done occupies the clock period ending at edge t+3+3n.
    check("clear_done_count", done_cnt, 1);
    check("clear_done_latency", done_cyc, 2 + 3 * n);
    check("lines_this_lock", lines_this_lock, lines);
    check("lines_total", lines_total, exp_total);
    check("shift_cycles", got.size(), exp_masks.size());
    for (int i = 0; i < got.size() && i < exp_masks.size(); i++)
      check("advance_row", got[i], exp_masks[i]);
    check("busy_profile_errors", busy_err, 0);
`ifdef LINE_CLEAR_SCORE_EN
    check("score_delta", score_delta, score_ref(lines));
`endif
  endtask

  typedef struct {
    logic [ROWS-1:0] board;
    bit              inject;
    int              exp_n;
    int              exp_lines;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int seen, hit;
    logic [ROWS-1:0] r;

    vecs[0] = '{20'h00000, 1'b0, 0, 0};   // nothing full
    vecs[1] = '{20'h80000, 1'b0, 1, 1};   // bottom row only
    vecs[2] = '{20'hA0400, 1'b0, 3, 3};   // rows 19, 17, 10
    vecs[3] = '{20'h00001, 1'b0, 1, 1};   // top row only
    vecs[4] = '{20'h00F00, 1'b0, 4, 4};   // four adjacent rows
    vecs[5] = '{20'hFFFFF, 1'b0, 20, 7};  // everything full, count saturates
    vecs[6] = '{20'hA0400, 1'b1, 3, 3};   // second lock while busy
    vecs[7] = '{20'h40002, 1'b0, 2, 2};   // rows 18 and 1

    reset = 1'b1;
    lock_pulse = 1'b0;
    board = '0;
    pend = '0;
    row_full = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_advance_row", advance_row, 0);
    check("reset_busy", busy, 0);
    check("reset_clear_done", clear_done, 0);
    check("reset_lines_this_lock", lines_this_lock, 0);
    check("reset_lines_total", lines_total, 0);
`ifdef LINE_CLEAR_SCORE_EN
    check("reset_score_delta", score_delta, 0);
`endif
    reset = 1'b0;
    step();

    // Reset in the middle of a SHIFT cycle.
    board = 20'h80000;
    row_full = board;
    lock_pulse = 1'b1;
    step();
    lock_pulse = 1'b0;
    hit = 0;
    for (int c = 0; c < 10 && hit == 0; c++) begin
      step();
      if (advance_row != '0) hit = 1;
    end
    check("reach_shift_before_reset", hit, 1);
    reset = 1'b1;
    #1;
    check("reset_mid_shift_advance_row", advance_row, 0);
    check("reset_mid_shift_busy", busy, 0);
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (clear_done || advance_row != '0) seen++;
    end
    reset = 1'b0;
    pend = '0;
    board = '0;
    row_full = '0;
    exp_total = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (clear_done || busy) seen++;
    end
    check("no_activity_after_reset_abort", seen, 0);

    foreach (vecs[i]) run_lock(vecs[i].board, vecs[i].inject, vecs[i].exp_n, vecs[i].exp_lines);

    for (int i = 0; i < 30; i++) begin
      r = ROWS'($urandom) & ROWS'($urandom);
      if (i % 5 == 0) r = r | ROWS'($urandom);
      run_lock(r, ($urandom_range(0, 3) == 0), -1, -1);
    end

    // Drive the running total into saturation, then a 4-line clear must hold it there.
    for (int i = 0; i < 40; i++) run_lock(20'hFFFFF, 1'b0, -1, -1);
    run_lock(20'h0F000, 1'b0, 4, 4);
    check("lines_total_saturated", lines_total, TOTAL_MAX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
